kat_sequencer: RTL and testbench

KAT_SEQUENCER -- requirements
Module: kat_sequencer

---
 rtl/kat_sequencer.sv | 173 +++++++++++++++++
 tb/tb_kat_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kat_sequencer.sv
// Known-answer-test sequencer: replays a small table of {pt, key, expected ct} vectors
// through an external 64/128 block cipher core and reports an aggregate pass/fail.
module kat_sequencer #(
  parameter int unsigned NUM_VEC = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       vec_wr_en,
  input  logic [$clog2(NUM_VEC)-1:0] vec_wr_addr,
  input  logic [63:0]                vec_wr_pt,
  input  logic [63:0]                vec_wr_exp,
  input  logic [127:0]               vec_wr_key,
  output logic                       cipher_start,
  output logic [63:0]                cipher_pt,
  output logic [127:0]               cipher_key,
  input  logic                       cipher_done,
  input  logic [63:0]                cipher_ct,
  output logic                       busy,
  output logic                       pass,
  output logic                       fail,
  output logic [7:0]                 err_count,
  output logic [$clog2(NUM_VEC)-1:0] vec_idx
);

  localparam int unsigned AW = $clog2(NUM_VEC);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StCheck,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   vec_idx_q, vec_idx_d;
  logic [7:0]      err_q, err_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            tmo_flag_q, tmo_flag_d;
  logic [63:0]     ct_q, ct_d;
  logic [63:0]     cipher_pt_q, cipher_pt_d;
  logic [127:0]    cipher_key_q, cipher_key_d;
  logic            cipher_start_q, cipher_start_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic            mismatch;
  logic [7:0]      err_inc;

  logic [63:0]     pt_mem  [NUM_VEC];
  logic [63:0]     exp_mem [NUM_VEC];
  logic [127:0]    key_mem [NUM_VEC];

  assign busy = (state_q == StLoad) || (state_q == StWait) || (state_q == StCheck);

  // The table is only writable while idle so a run always sees a stable set of vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        pt_mem[i]  <= '0;
        exp_mem[i] <= '0;
        key_mem[i] <= '0;
      end
    end else if (vec_wr_en && !busy) begin
      pt_mem[vec_wr_addr]  <= vec_wr_pt;
      exp_mem[vec_wr_addr] <= vec_wr_exp;
      key_mem[vec_wr_addr] <= vec_wr_key;
    end
  end

  always_comb begin
    state_d        = state_q;
    vec_idx_d      = vec_idx_q;
    err_d          = err_q;
    tmo_cnt_d      = tmo_cnt_q;
    tmo_flag_d     = tmo_flag_q;
    ct_d           = ct_q;
    cipher_pt_d    = cipher_pt_q;
    cipher_key_d   = cipher_key_q;
    cipher_start_d = 1'b0;
    pass_d         = pass_q;
    fail_d         = fail_q;
    mismatch       = tmo_flag_q || (ct_q != exp_mem[vec_idx_q]);
    err_inc        = (mismatch && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLoad;
          vec_idx_d  = '0;
          err_d      = '0;
          tmo_cnt_d  = '0;
          tmo_flag_d = 1'b0;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
        end
      end
      StLoad: begin
        cipher_pt_d    = pt_mem[vec_idx_q];
        cipher_key_d   = key_mem[vec_idx_q];
        cipher_start_d = 1'b1;
        tmo_cnt_d      = '0;
        tmo_flag_d     = 1'b0;
        state_d        = StWait;
      end
      StWait: begin
        // A done arriving on the last allowed cycle still counts as a real result.
        if (cipher_done) begin
          ct_d    = cipher_ct;
          state_d = StCheck;
        end else if (tmo_cnt_q == TW'(TIMEOUT)) begin
          tmo_flag_d = 1'b1;
          state_d    = StCheck;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StCheck: begin
        err_d      = err_inc;
        tmo_cnt_d  = '0;
        tmo_flag_d = 1'b0;
        if (vec_idx_q == AW'(NUM_VEC - 1)) begin
          state_d = StDone;
          pass_d  = (err_inc == 8'd0);
          fail_d  = (err_inc != 8'd0);
        end else begin
          vec_idx_d = vec_idx_q + 1'b1;
          state_d   = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      vec_idx_q      <= '0;
      err_q          <= '0;
      tmo_cnt_q      <= '0;
      tmo_flag_q     <= 1'b0;
      ct_q           <= '0;
      cipher_pt_q    <= '0;
      cipher_key_q   <= '0;
      cipher_start_q <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      vec_idx_q      <= vec_idx_d;
      err_q          <= err_d;
      tmo_cnt_q      <= tmo_cnt_d;
      tmo_flag_q     <= tmo_flag_d;
      ct_q           <= ct_d;
      cipher_pt_q    <= cipher_pt_d;
      cipher_key_q   <= cipher_key_d;
      cipher_start_q <= cipher_start_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
    end
  end

  assign cipher_start = cipher_start_q;
  assign cipher_pt    = cipher_pt_q;
  assign cipher_key   = cipher_key_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign err_count    = err_q;
  assign vec_idx      = vec_idx_q;

endmodule

// File: tb/tb_kat_sequencer.sv
// Self-checking bench for kat_sequencer with a stub cipher (ct = pt ^ key[63:0]).
module tb_kat_sequencer;

  localparam int NV  = 4;
  localparam int TMO = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         vec_wr_en = 1'b0;
  logic [1:0]   vec_wr_addr = '0;
  logic [63:0]  vec_wr_pt = '0;
  logic [63:0]  vec_wr_exp = '0;
  logic [127:0] vec_wr_key = '0;
  logic         cipher_start;
  logic [63:0]  cipher_pt;
  logic [127:0] cipher_key;
  logic         cipher_done;
  logic [63:0]  cipher_ct;
  logic         busy, pass, fail;
  logic [7:0]   err_count;
  logic [1:0]   vec_idx;

  always #5 clk = ~clk;

  kat_sequencer #(.NUM_VEC(NV), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .vec_wr_en   (vec_wr_en),
    .vec_wr_addr (vec_wr_addr),
    .vec_wr_pt   (vec_wr_pt),
    .vec_wr_exp  (vec_wr_exp),
    .vec_wr_key  (vec_wr_key),
    .cipher_start(cipher_start),
    .cipher_pt   (cipher_pt),
    .cipher_key  (cipher_key),
    .cipher_done (cipher_done),
    .cipher_ct   (cipher_ct),
    .busy        (busy),
    .pass        (pass),
    .fail        (fail),
    .err_count   (err_count),
    .vec_idx     (vec_idx)
  );

  // Stub cipher: done `stub_delay` cycles after cipher_start unless masked for that vector.
  int          stub_delay = 3;
  logic [15:0] sup_mask = '0;
  int          start_pulses = 0;
  int          run_base = 0;
  int          cyc = 0;
  int          stub_cnt = 0;
  logic        stub_done = 1'b0;
  logic        stub_sup = 1'b0;
  logic [63:0] stub_res = '0;
  logic        tb_done = 1'b0;
  int          pulse_at [16];
  int          cur_idx;

  assign cur_idx     = start_pulses - run_base;
  assign cipher_done = stub_done | tb_done;
  assign cipher_ct   = stub_res;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (cipher_start) begin
      start_pulses <= start_pulses + 1;
      if (cur_idx >= 0 && cur_idx < 16) pulse_at[cur_idx] <= cyc;
      stub_res <= cipher_pt ^ cipher_key[63:0];
      stub_sup <= sup_mask[cur_idx & 15];
      if (stub_delay <= 1) begin
        stub_cnt  <= 0;
        stub_done <= !sup_mask[cur_idx & 15];
      end else begin
        stub_cnt <= stub_delay - 1;
      end
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_done <= !stub_sup;
    end
  end

  int tests = 0;
  int fails = 0;

  logic [63:0]  tb_pt  [NV];
  logic [127:0] tb_key [NV];
  logic [63:0]  tb_exp [NV];

  typedef struct {
    logic [3:0] corrupt;
    logic [3:0] tmo;
    int         delay;
    logic [7:0] exp_err;
    logic       exp_pass;
  } row_t;

  row_t rows [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic write_entry(input int a, input logic [63:0] p, input logic [127:0] k,
                             input logic [63:0] e);
    vec_wr_en   = 1'b1;
    vec_wr_addr = 2'(a);
    vec_wr_pt   = p;
    vec_wr_key  = k;
    vec_wr_exp  = e;
    tick();
    vec_wr_en   = 1'b0;
  endtask

  task automatic set_base();
    tb_pt[0] = 64'h5734F006D8D88A3E; tb_key[0] = 128'h27a6781a43f364bc916708d5fbb5aefe;
    tb_pt[1] = 64'h0123456789ABCDEF; tb_key[1] = 128'h00112233445566778899AABBCCDDEEFF;
    tb_pt[2] = 64'hDEADBEEFCAFEF00D; tb_key[2] = 128'hFFEEDDCCBBAA99887766554433221100;
    tb_pt[3] = 64'h0F0F0F0F0F0F0F0F; tb_key[3] = 128'h13579BDF2468ACE013579BDF2468ACE0;
  endtask

  // Fill bench copy and DUT table; corrupted entries get one flipped expected bit.
  task automatic load_table(input logic [3:0] corrupt);
    for (int i = 0; i < NV; i++) begin
      tb_exp[i] = tb_pt[i] ^ tb_key[i][63:0];
      if (corrupt[i]) tb_exp[i] = tb_exp[i] ^ (64'h1 << (i * 13 + 5));
      write_entry(i, tb_pt[i], tb_key[i], tb_exp[i]);
    end
  endtask

  task automatic start_run();
    run_base = start_pulses;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s: run did not finish within 5000 cycles", name);
    end
  endtask

  // Expected error count from the table contents and the stub's behaviour per vector.
  function automatic int model_errs(input logic [3:0] tmo, input int delay);
    int e;
    e = 0;
    for (int i = 0; i < NV; i++)
      if (tmo[i] || delay > TMO || tb_exp[i] != (tb_pt[i] ^ tb_key[i][63:0])) e++;
    return e;
  endfunction

  task automatic check_run(input string name, input int exp_err);
    check({name, " busy"}, busy, 0);
    check({name, " pass"}, pass, exp_err == 0);
    check({name, " fail"}, fail, exp_err != 0);
    check({name, " err_count"}, err_count, exp_err);
    check({name, " pulses"}, start_pulses - run_base, NV);
    check({name, " vec_idx"}, vec_idx, NV - 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int err_a;
    logic [3:0] cm, tm;
    rows[0] = '{4'b0000, 4'b0000, 3,   8'd0, 1'b1};
    rows[1] = '{4'b0100, 4'b0000, 3,   8'd1, 1'b0};
    rows[2] = '{4'b0000, 4'b0010, 3,   8'd1, 1'b0};
    rows[3] = '{4'b1111, 4'b0000, 2,   8'd4, 1'b0};
    rows[4] = '{4'b0001, 4'b0001, 5,   8'd1, 1'b0};
    rows[5] = '{4'b0000, 4'b0000, 255, 8'd0, 1'b1};
    rows[6] = '{4'b0000, 4'b0000, 256, 8'd4, 1'b0};

    // Reset state
    #12;
    check("rst busy", busy, 0);
    check("rst pass", pass, 0);
    check("rst fail", fail, 0);
    check("rst cipher_start", cipher_start, 0);
    check("rst err_count", err_count, 0);
    rst_n = 1'b1;
    tick();

    // Stray done in IDLE
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    tick();
    check("stray done busy", busy, 0);
    check("stray done cipher_start", cipher_start, 0);
    check("stray done pass", pass, 0);

    // Latency of first cipher_start, then all-pass run
    set_base();
    load_table(4'b0000);
    stub_delay = 3;
    sup_mask = '0;
    run_base = start_pulses;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("lat busy", busy, 1);
    check("lat cs0", cipher_start, 0);
    tick();
    check("lat cs1", cipher_start, 1);
    check("lat pt", cipher_pt, tb_pt[0]);
    check("lat key", cipher_key, tb_key[0]);
    tick();
    check("lat cs2", cipher_start, 0);
    wait_idle("allpass");
    check_run("allpass", 0);

    // Table-driven scenarios
    for (int r = 0; r < 7; r++) begin
      load_table(rows[r].corrupt);
      stub_delay = rows[r].delay;
      sup_mask = {12'h0, rows[r].tmo};
      start_run();
      wait_idle($sformatf("row%0d", r));
      check_run($sformatf("row%0d", r), int'(rows[r].exp_err));
      check($sformatf("row%0d pass", r), pass, rows[r].exp_pass);
      if (r == 2) begin
        check("tmo normal period", pulse_at[1] - pulse_at[0], 3 + 3);
        check("tmo wait length", pulse_at[2] - pulse_at[1], TMO + 3);
      end
    end
    sup_mask = '0;

    // Back-to-back start from DONE after a failing run clears counters
    stub_delay = 2;
    load_table(4'b0100);
    start_run();
    wait_idle("b2b first");
    err_a = err_count;
    check("b2b first err", err_a, 1);
    start_run();
    check("b2b clr err", err_count, 0);
    check("b2b clr fail", fail, 0);
    check("b2b clr pass", pass, 0);
    check("b2b clr idx", vec_idx, 0);
    wait_idle("b2b second");
    check_run("b2b second", err_a);

    // Write and start in the same cycle: the rewritten entry is used
    load_table(4'b1000);
    tb_exp[3] = tb_pt[3] ^ tb_key[3][63:0];
    vec_wr_en = 1'b1; vec_wr_addr = 2'd3; vec_wr_pt = tb_pt[3];
    vec_wr_key = tb_key[3]; vec_wr_exp = tb_exp[3];
    start_run();
    vec_wr_en = 1'b0;
    wait_idle("wr+start");
    check_run("wr+start", 0);

    // Start and table writes during WAIT are dropped
    stub_delay = 6;
    start_run();
    tick();
    tick();
    start = 1'b1; vec_wr_en = 1'b1; vec_wr_addr = 2'd0;
    vec_wr_exp = ~tb_exp[0]; vec_wr_pt = 64'h1; vec_wr_key = '1;
    tick();
    start = 1'b0; vec_wr_en = 1'b0;
    wait_idle("busy wr");
    check_run("busy wr", model_errs(4'b0000, stub_delay));
    start_run();
    wait_idle("busy wr rerun");
    check_run("busy wr rerun", model_errs(4'b0000, stub_delay));

    // Reset during WAIT of vector 2
    stub_delay = 4;
    start_run();
    for (int n = 0; n < 200 && (start_pulses - run_base) < 3; n++) tick();
    check("rst mid reached v2", start_pulses - run_base, 3);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid busy", busy, 0);
    check("rst mid cs", cipher_start, 0);
    check("rst mid pass", pass, 0);
    check("rst mid fail", fail, 0);
    check("rst mid err", err_count, 0);
    check("rst mid idx", vec_idx, 0);
    check("rst mid pt", cipher_pt, 0);
    check("rst mid key", cipher_key, 0);
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) tick();
    check("post rst busy", busy, 0);
    check("post rst pass", pass, 0);
    check("post rst fail", fail, 0);
    start_run();
    wait_idle("cleared table");
    check("cleared table pt", cipher_pt, 0);
    check("cleared table key", cipher_key, 0);
    load_table(4'b0000);
    start_run();
    wait_idle("after reload");
    check_run("after reload", 0);

    // Randomized runs against the behavioural model
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NV; i++) begin
        tb_pt[i]  = {$urandom, $urandom};
        tb_key[i] = {$urandom, $urandom, $urandom, $urandom};
        cm[i] = ($urandom_range(0, 3) == 0);
        tm[i] = ($urandom_range(0, 9) == 0);
      end
      load_table(cm);
      stub_delay = $urandom_range(1, 8);
      sup_mask = {12'h0, tm};
      start_run();
      wait_idle($sformatf("rand%0d", it));
      check_run($sformatf("rand%0d", it), model_errs(tm, stub_delay));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
